// File: rtl/sram_boot_loader.sv
// rtl/sram_boot_loader.sv - boot sequencer: optional DSRAM zero-fill, ISRAM program load, then CPU handover
// Optional DSRAM clear pass is enabled by defining SRAM_BOOT_LOADER_CLEAR_EN.
module sram_boot_loader #(
    parameter int AW    = 14,
    parameter int DEPTH = 16384
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          boot_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_rst_hold,
    output logic          boot_done,
    output logic          boot_ovf,
    input  logic          cpu_i_cen_n,
    input  logic [3:0]    cpu_i_wen_n,
    input  logic [AW-1:0] cpu_i_addr,
    input  logic [31:0]   cpu_i_wdata,
    input  logic          cpu_d_cen_n,
    input  logic [3:0]    cpu_d_wen_n,
    input  logic [AW-1:0] cpu_d_addr,
    input  logic [31:0]   cpu_d_wdata,
    output logic          isram_cen_n,
    output logic [3:0]    isram_wen_n,
    output logic [AW-1:0] isram_addr,
    output logic [31:0]   isram_wdata,
    output logic          dsram_cen_n,
    output logic [3:0]    dsram_wen_n,
    output logic [AW-1:0] dsram_addr,
    output logic [31:0]   dsram_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          is_cen_q, is_cen_d;
    logic [3:0]    is_wen_q, is_wen_d;
    logic [AW-1:0] is_addr_q, is_addr_d;
    logic [31:0]   is_wdata_q, is_wdata_d;

    logic          ds_cen_q, ds_cen_d;
    logic [3:0]    ds_wen_q, ds_wen_d;
    logic [AW-1:0] ds_addr_q, ds_addr_d;

    logic          host_sel;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        is_cen_d   = 1'b1;
        is_wen_d   = 4'hF;
        is_addr_d  = is_addr_q;
        is_wdata_d = is_wdata_q;
        ds_cen_d   = 1'b1;
        ds_wen_d   = 4'hF;
        ds_addr_d  = ds_addr_q;
        case (state_q)
            IDLE: begin
                if (boot_start) begin
                    cnt_d = '0;
`ifdef SRAM_BOOT_LOADER_CLEAR_EN
                    // First zero write is launched on the same edge that enters CLEAR.
                    state_d   = CLEAR;
                    ds_cen_d  = 1'b0;
                    ds_wen_d  = 4'h0;
                    ds_addr_d = '0;
`else
                    state_d = LOAD;
`endif
                end
            end
`ifdef SRAM_BOOT_LOADER_CLEAR_EN
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    ds_cen_d  = 1'b0;
                    ds_wen_d  = 4'h0;
                    ds_addr_d = cnt_q + 1'b1;
                end
            end
`endif
            LOAD: begin
                if (ld_valid) begin
                    is_cen_d   = 1'b0;
                    is_wen_d   = 4'h0;
                    is_addr_d  = cnt_q;
                    is_wdata_d = {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]};
                    cnt_d      = cnt_q + 1'b1;
                    if (ld_last) begin
                        state_d = DONE;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            is_cen_q   <= 1'b1;
            is_wen_q   <= 4'hF;
            is_addr_q  <= '0;
            is_wdata_q <= '0;
            ds_cen_q   <= 1'b1;
            ds_wen_q   <= 4'hF;
            ds_addr_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            is_cen_q   <= is_cen_d;
            is_wen_q   <= is_wen_d;
            is_addr_q  <= is_addr_d;
            is_wdata_q <= is_wdata_d;
            ds_cen_q   <= ds_cen_d;
            ds_wen_q   <= ds_wen_d;
            ds_addr_q  <= ds_addr_d;
        end
    end

    // The final loader write lands in the first DONE cycle; handover waits until it has drained.
    assign host_sel     = (state_q == DONE) && is_cen_q && ds_cen_q;

    assign ld_ready     = (state_q == LOAD);
    assign boot_done    = (state_q == DONE);
    assign boot_ovf     = ovf_q;
    assign cpu_rst_hold = ~host_sel;

    assign isram_cen_n  = host_sel ? cpu_i_cen_n : is_cen_q;
    assign isram_wen_n  = host_sel ? cpu_i_wen_n : is_wen_q;
    assign isram_addr   = host_sel ? cpu_i_addr  : is_addr_q;
    assign isram_wdata  = host_sel ? cpu_i_wdata : is_wdata_q;

    assign dsram_cen_n  = host_sel ? cpu_d_cen_n : ds_cen_q;
    assign dsram_wen_n  = host_sel ? cpu_d_wen_n : ds_wen_q;
    assign dsram_addr   = host_sel ? cpu_d_addr  : ds_addr_q;
    assign dsram_wdata  = host_sel ? cpu_d_wdata : 32'h0;

endmodule

// File: tb/tb_sram_boot_loader.sv
// tb/tb_sram_boot_loader.sv - directed self-checking bench for sram_boot_loader
module tb_sram_boot_loader;

    localparam int AW    = 14;
    localparam int DEPTH = 16384;

    logic          hclk = 1'b0;
    logic          hrst = 1'b1;
    logic          boot_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready, cpu_rst_hold, boot_done, boot_ovf;
    logic          cpu_i_cen_n = 1'b1;
    logic [3:0]    cpu_i_wen_n = 4'hF;
    logic [AW-1:0] cpu_i_addr = '0;
    logic [31:0]   cpu_i_wdata = '0;
    logic          cpu_d_cen_n = 1'b1;
    logic [3:0]    cpu_d_wen_n = 4'hF;
    logic [AW-1:0] cpu_d_addr = '0;
    logic [31:0]   cpu_d_wdata = '0;
    logic          isram_cen_n, dsram_cen_n;
    logic [3:0]    isram_wen_n, dsram_wen_n;
    logic [AW-1:0] isram_addr, dsram_addr;
    logic [31:0]   isram_wdata, dsram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    sram_boot_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .hclk(hclk), .hrst(hrst), .boot_start(boot_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_rst_hold(cpu_rst_hold), .boot_done(boot_done), .boot_ovf(boot_ovf),
        .cpu_i_cen_n(cpu_i_cen_n), .cpu_i_wen_n(cpu_i_wen_n), .cpu_i_addr(cpu_i_addr), .cpu_i_wdata(cpu_i_wdata),
        .cpu_d_cen_n(cpu_d_cen_n), .cpu_d_wen_n(cpu_d_wen_n), .cpu_d_addr(cpu_d_addr), .cpu_d_wdata(cpu_d_wdata),
        .isram_cen_n(isram_cen_n), .isram_wen_n(isram_wen_n), .isram_addr(isram_addr), .isram_wdata(isram_wdata),
        .dsram_cen_n(dsram_cen_n), .dsram_wen_n(dsram_wen_n), .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata)
    );

    always #5 hclk = ~hclk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic do_reset();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        hrst     = 1'b1;
        @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);
    endtask

    // Pulses boot_start and returns at the first negedge of the LOAD state.
    task automatic start_boot(input string tag);
        int idx;
        int bad;
        boot_start = 1'b1;
        @(negedge hclk);
        boot_start = 1'b0;
`ifdef SRAM_BOOT_LOADER_CLEAR_EN
        idx = 0;
        bad = 0;
        for (int k = 0; k < 20000 && dsram_cen_n == 1'b0; k++) begin
            if (dsram_addr != AW'(idx) || dsram_wen_n != 4'h0 || dsram_wdata != 32'h0 ||
                ld_ready || !cpu_rst_hold || !isram_cen_n)
                bad++;
            idx++;
            @(negedge hclk);
        end
        check({tag, "_clr_count"}, idx, DEPTH);
        check({tag, "_clr_bad"}, bad, 0);
`else
        idx = 0;
        bad = 0;
        check({tag, "_dsram_idle"}, {31'b0, dsram_cen_n}, 1);
`endif
        check({tag, "_ready"}, {31'b0, ld_ready}, 1);
        check({tag, "_hold"}, {31'b0, cpu_rst_hold}, 1);
    endtask

    logic [31:0] bw_data [4] = '{32'h01020304, 32'hDEADBEEF, 32'h00FF00FF, 32'h12345678};
    logic [31:0] bw_exp  [4] = '{32'h04030201, 32'hEFBEADDE, 32'hFF00FF00, 32'h78563412};

    initial begin
        int prev_v;
        int wi;
        int nwr;
        int bad;
        logic [31:0] last_a;

        // Reset values, with CPU requests active to prove they are ignored
        cpu_i_cen_n = 1'b0; cpu_i_addr = 14'd5; cpu_d_cen_n = 1'b0; cpu_d_addr = 14'd9;
        @(negedge hclk);
        check("rst_hold", {31'b0, cpu_rst_hold}, 1);
        check("rst_done", {31'b0, boot_done}, 0);
        check("rst_ovf", {31'b0, boot_ovf}, 0);
        check("rst_ready", {31'b0, ld_ready}, 0);
        check("rst_is_ctl", {27'b0, isram_cen_n, isram_wen_n}, 32'h1F);
        check("rst_is_addr", {18'b0, isram_addr}, 0);
        check("rst_is_data", isram_wdata, 0);
        check("rst_ds_ctl", {27'b0, dsram_cen_n, dsram_wen_n}, 32'h1F);
        check("rst_ds_addr", {18'b0, dsram_addr}, 0);
        cpu_i_cen_n = 1'b1; cpu_d_cen_n = 1'b1;
        hrst = 1'b0;
        @(negedge hclk);
        check("idle_ready", {31'b0, ld_ready}, 0);

        // Boot A: two words, no bubbles
        start_boot("a");
        ld_valid = 1'b1; ld_data = 32'h11223344; ld_last = 1'b0;
        @(negedge hclk);
        check("a_w0_ctl", {27'b0, isram_cen_n, isram_wen_n}, 32'h00);
        check("a_w0_addr", {18'b0, isram_addr}, 0);
        check("a_w0_data", isram_wdata, 32'h44332211);
        ld_data = 32'hAABBCCDD; ld_last = 1'b1;
        @(negedge hclk);
        ld_valid = 1'b0; ld_last = 1'b0;
        check("a_w1_ctl", {27'b0, isram_cen_n, isram_wen_n}, 32'h00);
        check("a_w1_addr", {18'b0, isram_addr}, 1);
        check("a_w1_data", isram_wdata, 32'hDDCCBBAA);
        check("a_w1_done", {31'b0, boot_done}, 1);
        check("a_w1_hold", {31'b0, cpu_rst_hold}, 1);
        check("a_w1_ready", {31'b0, ld_ready}, 0);
        @(negedge hclk);
        check("a_rel_hold", {31'b0, cpu_rst_hold}, 0);
        check("a_rel_ovf", {31'b0, boot_ovf}, 0);
        check("a_rel_is_cen", {31'b0, isram_cen_n}, 1);
        // DONE passthrough is combinational
        cpu_i_cen_n = 1'b0; cpu_i_wen_n = 4'hF; cpu_i_addr = 14'd5;
        cpu_d_cen_n = 1'b0; cpu_d_wen_n = 4'h3; cpu_d_addr = 14'h1234; cpu_d_wdata = 32'hCAFEF00D;
        ld_valid = 1'b1; ld_data = 32'h55555555;
        #1;
        check("a_pt_is_addr", {18'b0, isram_addr}, 5);
        check("a_pt_is_ctl", {27'b0, isram_cen_n, isram_wen_n}, 32'h0F);
        check("a_pt_ds_addr", {18'b0, dsram_addr}, 32'h1234);
        check("a_pt_ds_data", dsram_wdata, 32'hCAFEF00D);
        check("a_extra_ready", {31'b0, ld_ready}, 0);
        @(negedge hclk);
        check("a_extra_addr", {18'b0, isram_addr}, 5);
        ld_valid = 1'b0;
        cpu_d_cen_n = 1'b1; cpu_d_wen_n = 4'hF;

        // Boot B: CPU request during LOAD is ignored; start pulse ignored; abort after 3 words
        do_reset();
        start_boot("b");
        boot_start = 1'b1;
        @(negedge hclk);
        boot_start = 1'b0;
        check("b_ign_is_cen", {31'b0, isram_cen_n}, 1);
        check("b_ign_is_addr", {18'b0, isram_addr}, 0);
        check("b_ign_ready", {31'b0, ld_ready}, 1);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA0A0A0A0 + i;
            @(negedge hclk);
        end
        ld_valid = 1'b0;
        check("b_w2_addr", {18'b0, isram_addr}, 2);
        hrst = 1'b1;
        #1;
        check("b_abort_is_ctl", {27'b0, isram_cen_n, isram_wen_n}, 32'h1F);
        check("b_abort_is_addr", {18'b0, isram_addr}, 0);
        check("b_abort_is_data", isram_wdata, 0);
        check("b_abort_ready", {31'b0, ld_ready}, 0);
        check("b_abort_hold", {31'b0, cpu_rst_hold}, 1);
        @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);
        cpu_i_cen_n = 1'b1; cpu_i_addr = '0;

        // Boot C: restart, then alternating valid/bubble with last on word 4
        start_boot("c");
        prev_v = 0;
        wi = 0;
        nwr = 0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                if (prev_v != 0) begin
                    if (isram_cen_n != 1'b0 || isram_wen_n != 4'h0 ||
                        isram_addr != AW'(wi - 1) || isram_wdata != bw_exp[wi-1])
                        bad++;
                end else if (isram_cen_n != 1'b1) begin
                    bad++;
                end
                if (isram_cen_n == 1'b0) nwr++;
            end
            if (i < 8 && (i % 2) == 0) begin
                ld_valid = 1'b1; ld_data = bw_data[wi]; ld_last = (i == 6);
                wi++;
                prev_v = 1;
            end else begin
                ld_valid = 1'b0; ld_last = 1'b0;
                prev_v = 0;
            end
            @(negedge hclk);
        end
        check("c_bubble_bad", bad, 0);
        check("c_write_count", nwr, 4);
        check("c_done", {31'b0, boot_done}, 1);
        check("c_ovf", {31'b0, boot_ovf}, 0);

        // Boot D: DEPTH words without ld_last -> overflow
        do_reset();
        start_boot("d");
        bad = 0;
        last_a = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i > 0) begin
                if (isram_cen_n != 1'b0 || isram_addr != AW'(i - 1) ||
                    isram_wdata != bswap(32'(i - 1)))
                    bad++;
                last_a = {18'b0, isram_addr};
            end
            if (i == DEPTH) begin
                check("d_ovf_ready", {31'b0, ld_ready}, 0);
                check("d_ovf_flag", {31'b0, boot_ovf}, 1);
                check("d_ovf_done", {31'b0, boot_done}, 1);
            end
            ld_valid = 1'b1; ld_data = 32'(i); ld_last = 1'b0;
            @(negedge hclk);
        end
        ld_valid = 1'b0;
        check("d_stream_bad", bad, 0);
        check("d_last_addr", last_a, 32'h3FFF);
        check("d_no_extra", {31'b0, isram_cen_n}, 1);
        check("d_hold", {31'b0, cpu_rst_hold}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_boot_loader.md
Name: sram_boot_loader

Overview:
- Hardware boot sequencer between the program-load stream (debug/flash/UART bridge) and the instruction/data SRAMs of the SMU.
- After a start pulse it zero-fills the data SRAM, then writes the incoming program words into the instruction SRAM with the SoC byte-lane order, holding the CPU in reset throughout.
- When the load completes it hands both SRAM ports to the CPU bus and releases the CPU reset hold.

Parameters:
- AW, 14, SRAM word-address width.
- DEPTH, 16384, words per SRAM (0x4000); must satisfy DEPTH <= 2**AW.

Ports:
- hclk  in  1  system clock.
- hrst  in  1  asynchronous active-high reset.
- boot_start  in  1  single-cycle start pulse; ignored outside IDLE.
- ld_valid  in  1  program word valid.
- ld_data  in  32  program word.
- ld_last  in  1  marks final program word; qualified by ld_valid.
- ld_ready  out  1  loader accepts a word this cycle.
- cpu_rst_hold  out  1  1 = keep CPU in reset.
- boot_done  out  1  load sequence complete.
- boot_ovf  out  1  DEPTH words accepted without ld_last.
- cpu_i_cen_n / cpu_i_wen_n[3:0] / cpu_i_addr[AW-1:0] / cpu_i_wdata[31:0]  in  CPU-side ISRAM request (active-low enables).
- cpu_d_cen_n / cpu_d_wen_n[3:0] / cpu_d_addr[AW-1:0] / cpu_d_wdata[31:0]  in  CPU-side DSRAM request.
- isram_cen_n / isram_wen_n[3:0] / isram_addr[AW-1:0] / isram_wdata[31:0]  out  ISRAM port.
- dsram_cen_n / dsram_wen_n[3:0] / dsram_addr[AW-1:0] / dsram_wdata[31:0]  out  DSRAM port.

Behaviour:
- Clock and reset: one clock, hclk. hrst is asynchronous and active-high.
- Reset values:
  - state = IDLE; cpu_rst_hold = 1; boot_done = 0; boot_ovf = 0; ld_ready = 0.
  - All SRAM cen_n and wen_n outputs = 1 (inactive); addr and wdata = 0.
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - SRAM ports inactive.
  - boot_start -> CLEAR, with the internal address counter set to 0.
- CLEAR:
  - Each cycle writes 0 to dsram at address cnt: dsram_cen_n = 0, wen_n = 4'b0000.
  - cnt increments every cycle. At cnt == DEPTH-1 the write is issued, then -> LOAD with cnt = 0.
  - Takes exactly DEPTH cycles.
  - ld_ready = 0 throughout.
- LOAD:
  - ld_ready = 1.
  - On ld_valid & ld_ready in cycle N, cycle N+1 drives isram_cen_n = 0, isram_wen_n = 4'b0000, isram_addr = cnt.
  - Byte swap on the write data: isram_wdata[7:0] = ld_data[31:24], [15:8] = ld_data[23:16], [23:16] = ld_data[15:8], [31:24] = ld_data[7:0].
  - cnt increments per accepted word. With no valid word, the ISRAM port is inactive that cycle.
  - Accepted word with ld_last -> DONE.
  - Accepted word at cnt == DEPTH-1 without ld_last -> DONE with boot_ovf = 1.
  - Both conditions in the same cycle -> DONE with boot_ovf = 0.
- DONE:
  - boot_done = 1; ld_ready = 0. Words presented after the last write are not accepted.
  - cpu_rst_hold = 0 starting the cycle after the final SRAM write is issued.
  - Both SRAM ports pass the cpu_* requests through combinationally.
  - Remains in DONE until hrst.
- In all states other than DONE the cpu_* inputs are ignored.
- A boot_start pulse arriving in CLEAR, LOAD or DONE has no effect.
- hrst asserted mid-CLEAR or mid-LOAD aborts immediately to the reset values. Partially written SRAM contents are undefined; a new boot_start restarts from CLEAR.
- All loader-driven SRAM outputs are registered (1-cycle latency from acceptance). The DONE passthrough is combinational.

Optional Feature:
- Macro: SRAM_BOOT_LOADER_CLEAR_EN.
- Defined: the CLEAR state exists as above.
- Undefined:
  - CLEAR is removed; boot_start goes IDLE -> LOAD directly.
  - The DSRAM port stays inactive until DONE.
  - Total boot latency drops by DEPTH cycles.

Test Plan:
- Reset, pulse boot_start, keep ld_valid = 0 -> exactly 16384 DSRAM zero writes at addr 0..0x3FFF; ld_ready rises in the cycle after the addr 0x3FFF write; cpu_rst_hold stays 1.
- Stream 0x11223344, 0xAABBCCDD (with ld_last), no bubbles -> ISRAM writes addr 0 data 0x44332211, addr 1 data 0xDDCCBBAA; boot_done = 1; cpu_rst_hold = 0 in the cycle after the second write; boot_ovf = 0.
- ld_valid toggled 1/0 for 4 words, last on word 4 -> exactly 4 writes at addrs 0..3, no writes in bubble cycles.
- 16384 words with no ld_last -> the last write is at 0x3FFF, then DONE with boot_ovf = 1. A 16385th valid word is not accepted (ld_ready = 0).
- hrst pulse during LOAD after 3 words -> all outputs at reset values within the same cycle. A new boot_start restarts CLEAR from addr 0.
- In DONE, CPU reads ISRAM addr 5 (cen_n = 0, wen_n = 4'hF) -> isram_addr = 5 the same cycle. In LOAD, the same CPU request leaves the ISRAM port driven by the loader only.
